// File: rtl/func_equiv_scanner.sv
// rtl/func_equiv_scanner.sv - sequential truth-table equivalence checker for two N-input functions
// Sweeps every minterm once, compares fa against fb outside the don't-care mask, reports count and lowest miss.
module func_equiv_scanner #(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop_first,
  input  logic [(1<<N)-1:0]  dc_mask,
  output logic [N-1:0]       minterm,
  input  logic               fa,
  input  logic               fb,
  output logic               busy,
  output logic               done,
  output logic               equiv,
  output logic               mm_found,
  output logic [N-1:0]       first_mm,
  output logic [N:0]         mm_cnt
);

  localparam int M = 1 << N;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state;
  logic [M-1:0]   mask_q;
  logic           stop_q;
  logic           mismatch;
  logic           last_mt;

  assign mismatch = (fa != fb) && !mask_q[minterm];
  assign last_mt  = (minterm == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mask_q   <= '0;
      stop_q   <= 1'b0;
      minterm  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      equiv    <= 1'b0;
      mm_found <= 1'b0;
      first_mm <= '0;
      mm_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            mask_q   <= dc_mask;
            stop_q   <= stop_first;
            minterm  <= '0;
            mm_cnt   <= '0;
            mm_found <= 1'b0;
            first_mm <= '0;
            equiv    <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          if (mismatch) begin
            mm_cnt <= mm_cnt + (N+1)'(1);
            if (!mm_found) begin
              first_mm <= minterm;
              mm_found <= 1'b1;
            end
          end
          // equiv must account for a mismatch seen on the exit cycle itself
          if (last_mt || (mismatch && stop_q)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            equiv <= (mm_cnt == '0) && !mismatch;
          end else begin
            minterm <= minterm + N'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_func_equiv_scanner.sv
// tb/tb_func_equiv_scanner.sv - randomized and directed bench for func_equiv_scanner (N=3 and N=4 instances)
module tb_func_equiv_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // truth tables driven onto each instance; fa/fb are combinational lookups of minterm
  logic [7:0]  fa3 = '0, fb3 = '0, mask3 = '0;
  logic [15:0] fa4 = '0, fb4 = '0, mask4 = '0;
  logic        start3 = 1'b0, stop3 = 1'b0, start4 = 1'b0, stop4 = 1'b0;

  logic [2:0] minterm3, first_mm3;
  logic [3:0] mm_cnt3;
  logic       busy3, done3, equiv3, found3;
  logic [3:0] minterm4, first_mm4;
  logic [4:0] mm_cnt4;
  logic       busy4, done4, equiv4, found4;
  logic       fa_in3, fb_in3, fa_in4, fb_in4;

  assign fa_in3 = fa3[minterm3];
  assign fb_in3 = fb3[minterm3];
  assign fa_in4 = fa4[minterm4];
  assign fb_in4 = fb4[minterm4];

  func_equiv_scanner #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .stop_first(stop3), .dc_mask(mask3),
    .minterm(minterm3), .fa(fa_in3), .fb(fb_in3), .busy(busy3), .done(done3),
    .equiv(equiv3), .mm_found(found3), .first_mm(first_mm3), .mm_cnt(mm_cnt3)
  );

  func_equiv_scanner #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop_first(stop4), .dc_mask(mask4),
    .minterm(minterm4), .fa(fa_in4), .fb(fb_in4), .busy(busy4), .done(done4),
    .equiv(equiv4), .mm_found(found4), .first_mm(first_mm4), .mm_cnt(mm_cnt4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int g_minterm(bit sel); return sel ? int'(minterm4) : int'(minterm3); endfunction
  function automatic int g_first(bit sel);   return sel ? int'(first_mm4) : int'(first_mm3); endfunction
  function automatic int g_cnt(bit sel);     return sel ? int'(mm_cnt4) : int'(mm_cnt3); endfunction
  function automatic int g_busy(bit sel);    return sel ? int'(busy4) : int'(busy3); endfunction
  function automatic int g_done(bit sel);    return sel ? int'(done4) : int'(done3); endfunction
  function automatic int g_equiv(bit sel);   return sel ? int'(equiv4) : int'(equiv3); endfunction
  function automatic int g_found(bit sel);   return sel ? int'(found4) : int'(found3); endfunction

  task automatic set_start(input bit sel, input bit v);
    if (sel) start4 = v; else start3 = v;
  endtask

  task automatic load(input bit sel, input logic [15:0] fa, input logic [15:0] fb,
                      input logic [15:0] mask, input bit stop);
    if (sel) begin
      fa4 = fa; fb4 = fb; mask4 = mask; stop4 = stop;
    end else begin
      fa3 = fa[7:0]; fb3 = fb[7:0]; mask3 = mask[7:0]; stop3 = stop;
    end
  endtask

  // Drives start from a falling edge; returns just after the accepting edge E0.
  task automatic start_scan(input bit sel, input logic [15:0] fa, input logic [15:0] fb,
                            input logic [15:0] mask, input bit stop);
    @(negedge clk);
    load(sel, fa, fb, mask, stop);
    set_start(sel, 1'b1);
    @(posedge clk);
  endtask

  // Follows a scan accepted at the previous edge and checks it against a truth-table walk.
  task automatic watch(input string name, input bit sel, input bit hold, input bit inject);
    int m, cyc, busy_n, exp_cnt, exp_first, exp_last, exp_done;
    bit exp_found, stopq, seen;
    logic [15:0] fa, fb, mask;
    m    = sel ? 16 : 8;
    fa   = sel ? fa4 : {8'h00, fa3};
    fb   = sel ? fb4 : {8'h00, fb3};
    mask = sel ? mask4 : {8'h00, mask3};
    stopq = sel ? stop4 : stop3;
    exp_cnt = 0; exp_first = 0; exp_found = 0; exp_last = m - 1;
    for (int k = 0; k < m; k++) begin
      if ((fa[k] != fb[k]) && !mask[k]) begin
        exp_cnt++;
        if (!exp_found) begin
          exp_found = 1; exp_first = k;
        end
        if (stopq) begin
          exp_last = k;
          break;
        end
      end
    end
    exp_done = exp_last + 2;
    cyc = 0; busy_n = 0; seen = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!hold) set_start(sel, 1'b0);
      if (inject && g_busy(sel) == 1 && g_minterm(sel) == 4) set_start(sel, 1'b1);
      if (g_done(sel) == 1) seen = 1;
      else if (g_busy(sel) == 1) busy_n++;
    end
    if (!seen) begin
      check({name, " done_timeout"}, 0, 1);
      return;
    end
    check({name, " done_cycle"}, cyc, exp_done);
    check({name, " busy_cycles"}, busy_n, exp_done - 1);
    check({name, " busy_at_done"}, g_busy(sel), 0);
    check({name, " equiv"}, g_equiv(sel), (exp_cnt == 0) ? 1 : 0);
    check({name, " mm_found"}, g_found(sel), int'(exp_found));
    check({name, " first_mm"}, g_first(sel), exp_first);
    check({name, " mm_cnt"}, g_cnt(sel), exp_cnt);
    check({name, " minterm_final"}, g_minterm(sel), exp_last);
    if (!hold) begin
      @(negedge clk);
      check({name, " done_one_cycle"}, g_done(sel), 0);
      check({name, " equiv_held"}, g_equiv(sel), (exp_cnt == 0) ? 1 : 0);
      check({name, " cnt_held"}, g_cnt(sel), exp_cnt);
    end
  endtask

  task automatic run(input string name, input bit sel, input logic [15:0] fa, input logic [15:0] fb,
                     input logic [15:0] mask, input bit stop, input bit inject);
    start_scan(sel, fa, fb, mask, stop);
    watch(name, sel, 1'b0, inject);
  endtask

  localparam logic [15:0] FA3 = 16'h00D9;
  localparam logic [15:0] FB3 = 16'h00D9;
  localparam logic [15:0] FA4 = 16'h161A;
  localparam logic [15:0] FB4 = 16'h1E1E;

  initial begin
    int to, dn, bz;
    logic [15:0] rfa, rfb, rmask;
    bit rsel;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst3 busy", busy3, 0);      check("rst3 done", done3, 0);
    check("rst3 equiv", equiv3, 0);    check("rst3 found", found3, 0);
    check("rst3 minterm", minterm3, 0); check("rst3 first", first_mm3, 0);
    check("rst3 cnt", mm_cnt3, 0);     check("rst4 cnt", mm_cnt4, 0);
    rst = 1'b0;

    run("base", 0, FA3, FB3, 16'h0, 0, 0);
    run("inv35", 0, FA3, FB3 ^ 16'h28, 16'h0, 0, 0);
    run("inv35_stop", 0, FA3, FB3 ^ 16'h28, 16'h0, 1, 0);
    run("inv35_dc", 0, FA3, FB3 ^ 16'h28, 16'h28, 0, 0);
    run("n4_dc", 1, FA4, FB4, 16'h0825, 0, 0);
    run("n4_nodc", 1, FA4, FB4, 16'h0, 0, 0);
    run("n4_stop", 1, FA4, FB4, 16'h0, 1, 0);
    run("restart_ignored", 0, FA3, FB3 ^ 16'h28, 16'h0, 0, 1);
    run("stop_at_last", 0, FA3, FB3 ^ 16'h80, 16'h0, 1, 0);

    // reset in the middle of a scan that has already counted mismatches
    start_scan(0, 16'h0000, 16'h00FF, 16'h0, 0);
    to = 0;
    do begin
      @(negedge clk);
      start3 = 1'b0;
      to++;
    end while (minterm3 != 3'd4 && to < 40);
    check("midrst reached4", minterm3, 4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", busy3, 0);     check("midrst done", done3, 0);
    check("midrst equiv", equiv3, 0);   check("midrst found", found3, 0);
    check("midrst minterm", minterm3, 0); check("midrst first", first_mm3, 0);
    check("midrst cnt", mm_cnt3, 0);
    dn = 0; bz = 0;
    repeat (12) begin
      @(negedge clk);
      dn += int'(done3);
      bz += int'(busy3);
    end
    check("midrst no_done", dn, 0);
    check("midrst idle", bz, 0);

    // back-to-back: start held through done, second scan loaded in the done cycle
    start_scan(0, FA3, FB3 ^ 16'h28, 16'h0, 0);
    watch("b2b_first", 0, 1, 0);
    load(0, FA3, FB3 ^ 16'h41, 16'h0, 0);
    @(posedge clk);
    watch("b2b_second", 0, 0, 0);

    for (int it = 0; it < 24; it++) begin
      rsel  = 1'($urandom_range(0, 1));
      rfa   = 16'($urandom);
      rfb   = rfa ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      rmask = 16'($urandom) & 16'($urandom);
      if (it % 3 == 0) begin
        start_scan(rsel, rfa, rfb, rmask, 1'($urandom_range(0, 1)));
        watch("rnd_hold", rsel, 1, 0);
        load(rsel, 16'($urandom), 16'($urandom), 16'($urandom) & 16'($urandom), 1'($urandom_range(0, 1)));
        @(posedge clk);
        watch("rnd_b2b", rsel, 0, 0);
      end else begin
        run("rnd", rsel, rfa, rfb, rmask, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
